mem_boot_loader: RTL



---
 rtl/mem_boot_loader_pkg.sv | 23 ++
 rtl/mem_boot_loader_mux.sv | 53 +++++
 rtl/mem_boot_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_boot_loader_pkg.sv
// Shared definitions for the boot loader and the CPU top that embeds it.
// Holds the boot FSM state encoding and the default memory geometry.
package mem_boot_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;

  // Encoding is fixed: the CPU top decodes these values directly.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_VRD  = 3'd2,
    ST_VCHK = 3'd3,
    ST_RUN  = 3'd4,
    ST_FAIL = 3'd5
  } boot_state_t;

  // True while the boot sequencer is working on an image.
  function automatic logic state_is_boot_busy(boot_state_t s);
    return (s == ST_LOAD) || (s == ST_VRD) || (s == ST_VCHK);
  endfunction

endpackage

// File: rtl/mem_boot_loader_mux.sv
// mem_port_mux: combinational owner-select for the single memory port.
//   state             : boot FSM state (selects the source)
//   ld_write/ld_addr/ld_data : loader write source (LOAD)
//   vrd_addr          : verify read address (VRD)
//   cpu_*             : CPU controller source (RUN only)
//   mem_*             : memory port; all zero when no source owns it
module mem_port_mux
  import mem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  boot_state_t       state,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] vrd_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_LOAD: begin
        mem_wr    = ld_write;
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
      end
      ST_VRD: begin
        mem_rd   = 1'b1;
        mem_addr = vrd_addr;
      end
      ST_RUN: begin
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: boot sequencer owning the 32x8 memory port.
// Holds the CPU in reset, streams an image from the byte loader into memory,
// optionally reads it back against a running checksum, then releases the CPU
// and passes the memory port through to the CPU controller.
//   clk, rst (async, active-low)
//   ld_start, ld_valid, ld_data, ld_ready : image loader interface
//   cpu_rd, cpu_wr, cpu_addr, cpu_wdata   : CPU controller memory request
//   mem_rdata, mem_rd, mem_wr, mem_addr, mem_wdata : memory port
//   cpu_rst, busy, done, err, word_count  : status
//   state                                 : FSM state for debug/observation
//
// Loader handshake: a byte transfers on every rising clk edge where
// ld_valid && ld_ready. ld_valid may be raised/lowered freely; ld_ready is
// high for the whole LOAD state and low everywhere else.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LOAD_WORDS = 32,
  parameter bit          VERIFY     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output boot_state_t       state
);

  localparam logic [ADDR_W:0]   LAST_WC = (ADDR_W+1)'(LOAD_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(LOAD_WORDS - 1);

  logic [DATA_W-1:0] checksum;
  logic [DATA_W-1:0] rsum;
  logic [DATA_W-1:0] rsum_next;
  logic [ADDR_W-1:0] rd_cnt;
  logic              ld_fire;

  assign ld_fire   = ld_valid & ld_ready;
  // Read data arrives one cycle after its strobe, so the sum trails the reads.
  assign rsum_next = rsum + mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cpu_rst    <= 1'b1;
      ld_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      checksum   <= '0;
      rsum       <= '0;
      rd_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN, ST_FAIL: begin
          if (ld_start) begin
            state      <= ST_LOAD;
            cpu_rst    <= 1'b1;
            ld_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
          end
        end
        ST_LOAD: begin
          if (ld_fire) begin
            word_count <= word_count + 1'b1;
            checksum   <= checksum + ld_data;
            if (word_count == LAST_WC) begin
              ld_ready <= 1'b0;
              if (VERIFY) begin
                state  <= ST_VRD;
                rd_cnt <= '0;
                rsum   <= '0;
              end else begin
                state   <= ST_RUN;
                busy    <= 1'b0;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end
            end
          end
        end
        ST_VRD: begin
          // The first read has no data back yet.
          if (rd_cnt != '0) rsum <= rsum_next;
          if (rd_cnt == LAST_RD) state <= ST_VCHK;
          else rd_cnt <= rd_cnt + 1'b1;
        end
        ST_VCHK: begin
          rsum <= rsum_next;
          busy <= 1'b0;
          if (rsum_next == checksum) begin
            state   <= ST_RUN;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            state <= ST_FAIL;
            err   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .state    (state),
    .ld_write (ld_fire),
    .ld_addr  (word_count[ADDR_W-1:0]),
    .ld_data  (ld_data),
    .vrd_addr (rd_cnt),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

endmodule
